// File: rtl/sync_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sync_ram_ctrl
//  Function : Single-port synchronous RAM with a req/ready handshake,
//             programmable wait states and a sequential clear sweep that
//             re-initialises every word after reset or on command.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_ram_ctrl #(
  parameter int                 DATA_W        = 8,
  parameter int                 ADDR_W        = 8,
  parameter int                 WAIT_STATES   = 0,
  parameter logic [DATA_W-1:0]  INIT_VAL      = '0,
  parameter bit                 WRITE_THROUGH = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clear,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy
);

  localparam logic [3:0] c_wait_init = 4'(WAIT_STATES);
  localparam bit         c_zero_wait = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic [3:0]          r_wait;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rvalid;
  logic                r_busy;
  logic [DATA_W-1:0]   r_mem [0:(2**ADDR_W)-1];

  logic                w_ready;
  logic                w_accept;
  logic                w_in_wait;
  logic                w_commit;
  logic                w_c_we;
  logic [ADDR_W-1:0]   w_c_addr;
  logic [DATA_W-1:0]   w_c_wdata;
  logic [DATA_W-1:0]   w_mem_q;

  // clear wins over a simultaneous request simply by dropping ready
  assign w_ready   = (r_state == ST_IDLE) && !clear;
  assign w_accept  = w_ready && req;
  assign w_in_wait = (r_state == ST_WAIT);

  // A commit is either the last wait cycle of a latched access or, with no
  // wait states, the accepting edge itself using the live inputs.
  assign w_commit  = w_in_wait ? (r_wait == 4'd1) : (w_accept && c_zero_wait);
  assign w_c_we    = w_in_wait ? r_we    : we;
  assign w_c_addr  = w_in_wait ? r_addr  : addr;
  assign w_c_wdata = w_in_wait ? r_wdata : wdata;
  assign w_mem_q   = r_mem[w_c_addr];

  assign ready  = w_ready;
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign busy   = r_busy;

  // Storage array: sweep writes INIT_VAL, otherwise committed writes land here
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_cnt] <= INIT_VAL;
    end else if (w_commit && w_c_we) begin
      r_mem[w_c_addr] <= w_c_wdata;
    end
  end

  // Controller state, access latch and registered read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_CLEAR;
      r_cnt    <= '0;
      r_wait   <= 4'd0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_busy   <= 1'b1;
    end else begin
      r_rvalid <= 1'b0;

      if (w_commit) begin
        if (!w_c_we) begin
          r_rdata  <= w_mem_q;
          r_rvalid <= 1'b1;
        end else if (WRITE_THROUGH) begin
          r_rdata  <= w_c_wdata;
        end
      end

      case (r_state)
        ST_CLEAR: begin
          r_cnt <= r_cnt + ADDR_W'(1);
          if (&r_cnt) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        ST_IDLE: begin
          if (clear) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else if (w_accept) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            if (!c_zero_wait) begin
              r_state <= ST_WAIT;
              r_wait  <= c_wait_init;
            end
          end
        end

        ST_WAIT: begin
          r_wait <= r_wait - 4'd1;
          if (r_wait == 4'd1) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_CLEAR;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sync_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_ram_ctrl
//  Function : Directed self-checking bench for sync_ram_ctrl. Five instances
//             with different parameter sets share one clock; each scenario
//             drives its own instance through index k.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sync_ram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance map: 0 = AW4 WS0 WT0, 1 = AW8 WS0, 2 = AW4 WS3,
  //               3 = AW4 WS2, 4 = AW4 WS0 WT1; all INIT_VAL = 8'hA5
  logic       rst    [5];
  logic       req    [5];
  logic       we     [5];
  logic       clear  [5];
  logic [7:0] addr   [5];
  logic [7:0] wdata  [5];
  logic       ready  [5];
  logic       rvalid [5];
  logic       busy   [5];
  logic [7:0] rdata  [5];

  int n_total = 0;
  int n_pass  = 0;

  sync_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .WAIT_STATES(0), .INIT_VAL(8'hA5), .WRITE_THROUGH(1'b0)) u_ws0 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0][3:0]), .wdata(wdata[0]),
    .clear(clear[0]), .ready(ready[0]), .rdata(rdata[0]), .rvalid(rvalid[0]), .busy(busy[0]));

  sync_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .WAIT_STATES(0), .INIT_VAL(8'hA5), .WRITE_THROUGH(1'b0)) u_aw8 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .clear(clear[1]), .ready(ready[1]), .rdata(rdata[1]), .rvalid(rvalid[1]), .busy(busy[1]));

  sync_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .WAIT_STATES(3), .INIT_VAL(8'hA5), .WRITE_THROUGH(1'b0)) u_ws3 (
    .clk(clk), .rst(rst[2]), .req(req[2]), .we(we[2]), .addr(addr[2][3:0]), .wdata(wdata[2]),
    .clear(clear[2]), .ready(ready[2]), .rdata(rdata[2]), .rvalid(rvalid[2]), .busy(busy[2]));

  sync_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .WAIT_STATES(2), .INIT_VAL(8'hA5), .WRITE_THROUGH(1'b0)) u_ws2 (
    .clk(clk), .rst(rst[3]), .req(req[3]), .we(we[3]), .addr(addr[3][3:0]), .wdata(wdata[3]),
    .clear(clear[3]), .ready(ready[3]), .rdata(rdata[3]), .rvalid(rvalid[3]), .busy(busy[3]));

  sync_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .WAIT_STATES(0), .INIT_VAL(8'hA5), .WRITE_THROUGH(1'b1)) u_wt1 (
    .clk(clk), .rst(rst[4]), .req(req[4]), .we(we[4]), .addr(addr[4][3:0]), .wdata(wdata[4]),
    .clear(clear[4]), .ready(ready[4]), .rdata(rdata[4]), .rvalid(rvalid[4]), .busy(busy[4]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while ((busy[k] !== 1'b0 || ready[k] !== 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("idle_%0d", k), busy[k], 1'b0);
  endtask

  // called at a negedge with ready high; returns at the negedge showing rvalid
  task automatic do_read(input int k, input logic [7:0] a, input logic [7:0] exp, input string tag);
    int n = 0;
    req[k] = 1'b1; we[k] = 1'b0; addr[k] = a;
    @(negedge clk);
    req[k] = 1'b0;
    while (rvalid[k] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_rv"}, rvalid[k], 1'b1);
    check_eq(tag, rdata[k], exp);
  endtask

  task automatic do_write(input int k, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    req[k] = 1'b1; we[k] = 1'b1; addr[k] = a; wdata[k] = d;
    @(negedge clk);
    req[k] = 1'b0; we[k] = 1'b0;
    while (ready[k] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int bad;
    int stalls;

    for (int k = 0; k < 5; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; clear[k] = 1'b0;
      addr[k] = 8'h00; wdata[k] = 8'h00;
    end
    repeat (3) @(negedge clk);

    // reset state
    check_eq("rst_busy",   busy[0],   1'b1);
    check_eq("rst_ready",  ready[0],  1'b0);
    check_eq("rst_rvalid", rvalid[0], 1'b0);
    check_eq("rst_rdata",  rdata[0],  8'h00);

    // release and measure the sweep length of the 16-word instance
    for (int k = 0; k < 5; k++) rst[k] = 1'b0;
    cyc = 0;
    while (busy[0] === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check_eq("sweep_len",   cyc,      16);
    check_eq("sweep_ready", ready[0], 1'b1);

    // read all 16 words back-to-back: each returns INIT_VAL with rvalid
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'(i);
      @(negedge clk);
      if (rvalid[0] !== 1'b1 || rdata[0] !== 8'hA5) bad++;
    end
    req[0] = 1'b0;
    @(negedge clk);
    check_eq("sweep_reads",  bad,       0);
    check_eq("rvalid_drops", rvalid[0], 1'b0);

    // back-to-back write then read of 8'h10 on the 256-word instance
    wait_idle(1);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'h10; wdata[1] = 8'h3C;
    @(negedge clk);
    check_eq("b2b_ready", ready[1], 1'b1);
    we[1] = 1'b0;
    @(negedge clk);
    req[1] = 1'b0;
    check_eq("b2b_rvalid", rvalid[1], 1'b1);
    check_eq("b2b_rdata",  rdata[1],  8'h3C);

    // 16 alternating writes/reads without a stall
    stalls = 0;
    bad    = 0;
    for (int j = 0; j < 16; j++) begin
      if (ready[1] !== 1'b1) stalls++;
      req[1]   = 1'b1;
      we[1]    = (j % 2 == 0);
      addr[1]  = 8'(8'h20 + j / 2);
      wdata[1] = 8'(8'h40 + j / 2);
      @(negedge clk);
      if (j % 2 == 1) begin
        if (rvalid[1] !== 1'b1 || rdata[1] !== 8'(8'h40 + j / 2)) bad++;
      end else begin
        if (rvalid[1] !== 1'b0) bad++;
      end
    end
    if (ready[1] !== 1'b1) stalls++;
    req[1] = 1'b0;
    check_eq("alt_stalls", stalls, 0);
    check_eq("alt_data",   bad,    0);

    // three wait states: ready low E1..E3, rvalid only at E4
    wait_idle(2);
    do_write(2, 8'h07, 8'hC3);
    check_eq("ws3_ready_E0", ready[2], 1'b1);
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 8'h07;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check_eq($sformatf("ws3_ready_E%0d", c),  ready[2],  (c == 4));
      check_eq($sformatf("ws3_rvalid_E%0d", c), rvalid[2], (c == 4));
    end
    check_eq("ws3_rdata", rdata[2], 8'hC3);
    req[2] = 1'b0;
    @(negedge clk);
    check_eq("ws3_no_dup_rv",  rvalid[2], 1'b0);
    check_eq("ws3_no_dup_rdy", ready[2],  1'b1);

    // clear and a write request together: clear wins
    clear[0] = 1'b1; req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h00; wdata[0] = 8'hFF;
    #1;
    check_eq("clr_ready", ready[0], 1'b0);
    @(negedge clk);
    clear[0] = 1'b0; req[0] = 1'b0; we[0] = 1'b0;
    check_eq("clr_busy", busy[0], 1'b1);
    wait_idle(0);
    do_read(0, 8'h00, 8'hA5, "clr_addr0");

    // reset while a two-wait-state write is pending
    wait_idle(3);
    do_read(3, 8'h01, 8'hA5, "ws2_pre");
    req[3] = 1'b1; we[3] = 1'b1; addr[3] = 8'h05; wdata[3] = 8'h77;
    @(negedge clk);
    req[3] = 1'b0; we[3] = 1'b0;
    rst[3] = 1'b1;
    #1;
    check_eq("mid_rst_rvalid", rvalid[3], 1'b0);
    check_eq("mid_rst_rdata",  rdata[3],  8'h00);
    check_eq("mid_rst_busy",   busy[3],   1'b1);
    @(negedge clk);
    rst[3] = 1'b0;
    wait_idle(3);
    do_read(3, 8'h05, 8'hA5, "ws2_addr5");

    // write-through loads rdata on commit, rvalid stays low
    wait_idle(4);
    do_read(4, 8'h03, 8'hA5, "wt1_pre");
    req[4] = 1'b1; we[4] = 1'b1; addr[4] = 8'h03; wdata[4] = 8'h5A;
    @(negedge clk);
    req[4] = 1'b0; we[4] = 1'b0;
    check_eq("wt1_rdata",  rdata[4],  8'h5A);
    check_eq("wt1_rvalid", rvalid[4], 1'b0);

    // without write-through the same write leaves rdata alone
    do_read(0, 8'h03, 8'hA5, "wt0_pre");
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h03; wdata[0] = 8'h5A;
    @(negedge clk);
    req[0] = 1'b0; we[0] = 1'b0;
    check_eq("wt0_rdata",  rdata[0],  8'hA5);
    check_eq("wt0_rvalid", rvalid[0], 1'b0);
    do_read(0, 8'h03, 8'h5A, "wt0_mem");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_ram_ctrl.md
# sync_ram_ctrl

Parametrised single-port synchronous RAM with a request/ready handshake, programmable wait states and a hardware clear engine. It replaces the fixed 256x8 combinational data memory of the 8-bit CPU. Width, depth and access latency are configurable. Contents are re-initialised by a sequential sweep after every reset or on command.

## Interface
- DATA_W, 8, data word width in bits
- ADDR_W, 8, address width; depth = 2**ADDR_W words
- WAIT_STATES, 0, extra cycles per access (0..15)
- INIT_VAL, 0, value written to every word by the clear sweep (DATA_W bits)
- WRITE_THROUGH, 0, 1 = a committed write also loads wdata into rdata
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  1  access request
- we  input  1  1 = write, 0 = read; qualified by req
- addr  input  ADDR_W  word address
- wdata  input  DATA_W  write data
- clear  input  1  request a full re-initialisation sweep (level, sampled in IDLE)
- ready  output  1  controller accepts req this cycle
- rdata  output  DATA_W  read data, registered
- rvalid  output  1  one-cycle pulse: rdata holds a read result
- busy  output  1  clear sweep in progress

## Operation
- States: CLEAR, IDLE, WAIT.
- rst asserted (any time, any state) -> CLEAR. Sweep counter = 0. ready=0, rvalid=0, rdata=0, busy=1. Any in-flight access is discarded and not committed.
- CLEAR: one word per cycle, mem[cnt] <= INIT_VAL, cnt++. After the word at address 2**ADDR_W-1 is written -> IDLE. req is ignored and ready=0 throughout.
- IDLE: ready = !clear (combinational).
  - clear=1 -> CLEAR on the next edge; clear has priority over a simultaneous req.
  - req && ready: latch we/addr/wdata.
    - WAIT_STATES=0: commit on the same edge and stay IDLE.
    - Otherwise: go to WAIT with wait counter = WAIT_STATES.
- WAIT: ready=0. Counter decrements each cycle. clear and req are ignored. On the edge where the counter reaches 0: commit the latched access and go to IDLE.
- Commit, read: rdata <= mem[addr]. rvalid=1 for exactly the following cycle.
- Commit, write: mem[addr] <= wdata. rvalid stays 0. rdata <= wdata if WRITE_THROUGH=1, otherwise rdata is unchanged.
- rdata holds its value until the next read commit, write-through commit, or reset.
- Address arithmetic is modulo 2**ADDR_W. No out-of-range case exists. The sweep counter wraps only on exit from CLEAR.

## Timing
- Clear sweep: busy high for exactly 2**ADDR_W cycles after rst deasserts (or after the edge that enters CLEAR from IDLE). ready rises in the first IDLE cycle.
- Read latency, with acceptance at edge E0:
  - rvalid is sampled high at edge E(WAIT_STATES+1) and low at every other edge.
  - For WAIT_STATES=0, rdata/rvalid are valid at E1.
- Write commit edge: E(WAIT_STATES). A read accepted at or after the next accepting edge returns the new data.
- Throughput: WAIT_STATES=0 gives one access per cycle, back-to-back. Otherwise one access per WAIT_STATES+1 cycles; ready is low for WAIT_STATES cycles after each acceptance.
- Read-after-write to the same address, back-to-back at E0/E1 with WAIT_STATES=0, returns the written value at E2.
- req deasserted while ready=0 has no effect. Nothing is queued.
- rst asserted mid-WAIT: the pending write is not committed. rvalid drops to 0 immediately (asynchronously).

## Test plan
- Reset sweep, ADDR_W=4, INIT_VAL=8'hA5:
  - Release rst: busy is high for 16 cycles, then ready=1.
  - Read all 16 addresses: each returns 8'hA5, and rvalid pulses once per read.
- Back-to-back, WAIT_STATES=0: write 8'h3C to addr 8'h10 at E0, read addr 8'h10 at E1 -> rdata=8'h3C, rvalid=1 at E2. 16 alternating writes and reads show no stalls (ready stays 1).
- WAIT_STATES=3: read accepted at E0.
  - ready is sampled 0 at E1..E3 and 1 at E4.
  - rvalid=1 only at E4, carrying the stored value.
  - req held high during the stall is not accepted twice.
- clear vs req: in IDLE, clear=1 and req=1 (write 8'hFF to addr 0) on the same cycle.
  - The write is not performed and busy rises.
  - After the sweep, addr 0 reads INIT_VAL.
- Reset mid-access, WAIT_STATES=2: write 8'h77 to addr 5 accepted, then rst pulsed one cycle later.
  - rvalid=0 and rdata=0 immediately.
  - After the sweep, addr 5 reads INIT_VAL, not 8'h77.
- WRITE_THROUGH=1: write 8'h5A -> rdata=8'h5A on the commit edge with rvalid=0. With WRITE_THROUGH=0 the same write leaves rdata unchanged.
